// File: rtl/f32_pkg.sv
// Shared float32 field layout, Q1.31 limits and pipeline payload types.
package f32_pkg;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MAN_W    = 23;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam int unsigned Q31_W    = 32;
  localparam int unsigned SH_W     = 7;

  localparam logic [Q31_W-1:0] Q31_MAX = 32'h7FFF_FFFF;
  localparam logic [Q31_W-1:0] Q31_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_BIG,
    CLS_INF,
    CLS_NAN
  } cls_e;

  typedef struct packed {
    cls_e             cls;
    logic             sign;
    logic             neg_one;
    logic [Q31_W-1:0] aligned;
    logic [SH_W-1:0]  sh;
  } s1_t;

  typedef struct packed {
    cls_e             cls;
    logic             sign;
    logic             neg_one;
    logic [Q31_W-1:0] mag;
  } s2_t;

endpackage

// File: rtl/rshift_32bit.sv
// Combinational logarithmic right shifter; shifts of 32 or more give zero.
module rshift_32bit
  import f32_pkg::*;
(
  input  logic [Q31_W-1:0] din,
  input  logic [SH_W-1:0]  sh,
  output logic [Q31_W-1:0] dout
);

  logic [Q31_W-1:0] stage;

  always_comb begin
    stage = din;
    for (int i = 0; i < 5; i++) begin
      if (sh[i]) stage = stage >> (1 << i);
    end
    dout = (|sh[SH_W-1:5]) ? '0 : stage;
  end

endmodule

// File: rtl/float32_to_q31.sv
// float32 -> signed Q1.31 converter: 3-stage pipeline (classify, shift, sign/saturate)
// with valid/ready handshaking and a saturating sat/NaN event counter.
module float32_to_q31
  import f32_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_sat,
  output logic             out_nan,
  output logic [CNT_W-1:0] evt_cnt,
  input  logic             evt_cnt_clr
);

  logic             en;
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d, out_nan_q, out_nan_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [31:0]      mag_c;
  logic             s_in;
  logic [7:0]       e_in;
  logic [22:0]      m_in;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_nan   = out_nan_q;
  assign evt_cnt   = evt_cnt_q;

  assign s_in = in_data[SIGN_BIT];
  assign e_in = in_data[EXP_MSB:EXP_LSB];
  assign m_in = in_data[MAN_W-1:0];

  // Stage 1: unpack and classify; sh is only meaningful for CLS_NORM.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (en) begin
      s1_valid_d     = in_valid;
      s1_d.sign      = s_in;
      s1_d.neg_one   = s_in && (e_in == 8'(EXP_BIAS)) && (m_in == '0);
      s1_d.aligned   = {1'b0, 1'b1, m_in, 7'b0};
      s1_d.sh        = 7'(8'd126 - e_in);
      if (e_in == 8'(EXP_MAX))       s1_d.cls = (m_in != '0) ? CLS_NAN : CLS_INF;
      else if (e_in >= 8'(EXP_BIAS)) s1_d.cls = CLS_BIG;
      else if (e_in == 8'd0)         s1_d.cls = CLS_ZERO;
      else                           s1_d.cls = CLS_NORM;
    end
  end

  rshift_32bit u_shift (
    .din  (s1_q.aligned),
    .sh   (s1_q.sh),
    .dout (mag_c)
  );

  // Stage 2: magnitude alignment.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (en) begin
      s2_valid_d   = s1_valid_q;
      s2_d.cls     = s1_q.cls;
      s2_d.sign    = s1_q.sign;
      s2_d.neg_one = s1_q.neg_one;
      s2_d.mag     = mag_c;
    end
  end

  // Stage 3: apply sign, saturate out-of-range values, flag NaN.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_nan_d   = out_nan_q;
    if (en) begin
      out_valid_d = s2_valid_q;
      out_data_d  = '0;
      out_sat_d   = 1'b0;
      out_nan_d   = 1'b0;
      unique case (s2_q.cls)
        CLS_NORM: out_data_d = s2_q.sign ? (~s2_q.mag + 32'd1) : s2_q.mag;
        CLS_BIG, CLS_INF: begin
          out_data_d = s2_q.sign ? Q31_MIN : Q31_MAX;
          out_sat_d  = !s2_q.neg_one;
        end
        CLS_NAN:  out_nan_d = 1'b1;
        default:  out_data_d = '0;
      endcase
    end
  end

  // Event counter: clear wins, saturates at all-ones.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (evt_cnt_clr) begin
      evt_cnt_d = '0;
    end else if (out_valid_q && out_ready && (out_sat_q || out_nan_q) && (evt_cnt_q != '1)) begin
      evt_cnt_d = evt_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_nan_q   <= 1'b0;
      evt_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s2_valid_q  <= s2_valid_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_nan_q   <= out_nan_d;
      evt_cnt_q   <= evt_cnt_d;
    end
  end

endmodule

// File: tb/tb_float32_to_q31.sv
// Directed scoreboard bench for float32_to_q31 using an independent real-arithmetic model.
module tb_float32_to_q31;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_sat;
  logic             out_nan;
  logic [CNT_W-1:0] evt_cnt;
  logic             evt_cnt_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [33:0] sb[$];          // {nan, sat, data}
  logic        stall_prev = 1'b0;
  logic [31:0] held_data;

  float32_to_q31 #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_nan(out_nan),
    .evt_cnt(evt_cnt), .evt_cnt_clr(evt_cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact real value scaled by 2^31, truncated toward zero.
  function automatic logic [33:0] model(input logic [31:0] f);
    int  e;
    int  m;
    real x;
    e = int'(f[30:23]);
    m = int'(f[22:0]);
    if (e == 255) return (m != 0) ? {2'b10, 32'h0} : {2'b01, (f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    if (e == 0) x = real'(m) * (2.0 ** (-149 + 31));
    else        x = (8388608.0 + real'(m)) * (2.0 ** (e - 150 + 31));
    if (f[31]) x = -x;
    if (x >= 2147483648.0)  return {2'b01, 32'h7FFF_FFFF};
    if (x == -2147483648.0) return {2'b00, 32'h8000_0000};
    if (x < -2147483648.0)  return {2'b01, 32'h8000_0000};
    return {2'b00, 32'($rtoi(x))};
  endfunction

  // Output monitor: pops the scoreboard on each output transfer, checks stall stability.
  always @(negedge clk) begin
    if (!reset) begin
      if (stall_prev) check("stall_hold", out_data, held_data);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          logic [33:0] exp;
          exp = sb.pop_front();
          check("data", out_data, exp[31:0]);
          check("sat", 32'(out_sat), 32'(exp[32]));
          check("nan", 32'(out_nan), 32'(exp[33]));
        end
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Holds in_valid until accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [31:0] d);
    logic rdy;
    bit   done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        sb.push_back(model(d));
        done = 1;
      end
      #1;
    end
    if (!done) check("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (sb.size() != 0 && i < 2000) begin
      @(posedge clk); #1;
      i++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; evt_cnt_clr = 1'b0;
    idle(2);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_flags", {30'd0, out_sat, out_nan}, 32'd0);
    check("rst_evt_cnt", 32'(evt_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Latency: accept edge is edge 1, out_valid visible after edge 3.
    send(32'h3F00_0000);
    check("lat_e1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e3", 32'(out_valid), 32'd1);
    drain();

    send(32'hBF00_0000);
    send(32'h3E80_0001);
    drain();

    // Saturation set: three sat beats, exact -1.0 not counted.
    send(32'h3F80_0000);
    send(32'hBF80_0000);
    send(32'hC2C8_0000);
    send(32'h7F80_0000);
    drain();
    check("evt_cnt_3", 32'(evt_cnt), 32'd3);

    send(32'h7FC0_0000);
    send(32'h0000_0001);
    send(32'h8000_0000);
    send(32'h2F80_0000);
    send(32'h3000_0000);
    drain();
    check("evt_cnt_4", 32'(evt_cnt), 32'd4);

    // Backpressure: out_ready low on cycles 2..5 while 6 beats stream in.
    fork
      begin
        send(32'h3F00_0000);
        send(32'h3E80_0000);
        send(32'hBE00_0000);
        send(32'h3F40_0000);
        send(32'hBF7F_FFFF);
        send(32'h3C00_0000);
      end
      begin
        for (int c = 1; c <= 14; c++) begin
          out_ready = !(c >= 2 && c <= 5);
          @(negedge clk);
          if (out_valid && !out_ready) check("bp_in_ready", 32'(in_ready), 32'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Counter saturation.
    for (int i = 0; i < 32'hFFFF + 2; i++) send(32'h4000_0000);
    drain();
    check("evt_cnt_sat", 32'(evt_cnt), 32'h0000_FFFF);

    // Clear coincident with a saturating transfer.
    send(32'hC000_0000);
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    check("clr_pre_valid", 32'(out_valid), 32'd1);
    evt_cnt_clr = 1'b1;
    @(posedge clk); #1;
    evt_cnt_clr = 1'b0;
    check("clr_priority", 32'(evt_cnt), 32'd0);
    drain();

    // Reset with three beats in flight.
    send(32'h3F80_0000);
    drain();
    check("pre_rst_cnt", 32'(evt_cnt), 32'd1);
    send(32'h3F80_0000);
    send(32'h3F00_0000);
    send(32'h7F80_0000);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    sb.delete();
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd0);
    end
    check("post_rst_cnt", 32'(evt_cnt), 32'd0);
    check("post_rst_sb", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
